time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
- Mode/edit controller for the clock's hour, minute and second counter units.
- Owns the shared 6-bit readback databus: only this block asserts the per-unit bus enables, and it time-multiplexes them.
- In RUN it forwards the 1 Hz tick to the seconds chain and round-robin scans the three counters into display registers.
- In SET it freezes counting, fetches the selected unit's value, edits it with an increment button, and writes it back through that unit's load/data port.

Parameters:
- W, 6, counter/bus width.
- HR_MAX, 23, hour wrap value.
- MS_MAX, 59, minute/second wrap value.

Ports:
- clk  in  1  system clock.
- clear_n  in  1  reset: synchronous, active-low.
- mode_btn  in  1  debounced level; rising edge advances mode.
- inc_btn  in  1  debounced level; rising edge increments the edit value.
- tick_1hz  in  1  one-cycle pulse.
- databus  in  W  shared readback bus from counter units.
- count_en  out  1  tick forwarded to seconds chain (gated).
- sec_en, min_en, hr_en  out  1 each  bus enables.
- sec_load, min_load, hr_load  out  1 each  one-cycle load strobes.
- load_data  out  W  value driven with a load strobe.
- disp_sec, disp_min, disp_hr  out  W each  scanned display values.
- edit_val  out  W  current edit value.
- mode  out  2  00=RUN, 01=HR, 10=MIN, 11=SEC.

Behaviour:
- Reset (clear_n=0 at a clk edge):
  - state=RUN, scan pointer=SEC, edit_val=0, all disp_*=0, load_data=0.
  - All load strobes, enables and count_en deasserted.
  - Edge-detect history registers cleared.
  - Reset mid-SET abandons the edit with no load strobe issued.
- Button edges:
  - Internal prev registers; edge = btn & ~prev. One action per press; holding a button repeats nothing.
- FSM states: RUN, FETCH_HR, EDIT_HR, FETCH_MIN, EDIT_MIN, FETCH_SEC, EDIT_SEC.
- RUN:
  - count_en = tick_1hz (combinational pass-through).
  - Exactly one of sec_en/min_en/hr_en is high each cycle, decoded from the scan pointer, which rotates SEC->MIN->HR->SEC every cycle.
  - At each edge, databus is captured into disp_* for the unit enabled that cycle.
  - mode edge -> FETCH_HR.
- FETCH_x:
  - x_en=1, other enables 0, count_en=0.
  - Next edge: edit_val<=databus, go to EDIT_x.
  - Button edges are ignored in this state.
- EDIT_x:
  - No bus enable; count_en=0. tick_1hz is dropped, not queued.
  - inc edge: edit_val <= (edit_val>=MAX_x) ? 0 : edit_val+1, where MAX_x is HR_MAX for hours and MS_MAX otherwise.
  - mode edge:
    - Next cycle x_load=1 and load_data=edit_val; both are registered and last one cycle.
    - Transition EDIT_HR->FETCH_MIN, EDIT_MIN->FETCH_SEC, EDIT_SEC->RUN.
    - When the target is RUN, the scan pointer restarts at SEC.
- Simultaneous mode and inc edges: mode wins, the increment is discarded, and the committed value is the pre-increment edit_val.
- Enables are one-hot-or-zero in every cycle. A load strobe never coincides with count_en.
- Out-of-range fetched value (>MAX): the first inc wraps it to 0.
- The mode output is decoded from state: both FETCH_x and EDIT_x map to x's code.
- Latency:
  - mode edge to fetch enable: 1 cycle.
  - Fetch to edit_val valid: 1 cycle.
  - mode edge in EDIT to load strobe: 1 cycle.
  - Display staleness: at most 3 cycles.

Decomposition:
- Package time_ctrl_pkg:
  - State enum.
  - Mode codes.
  - Default W, HR_MAX, MS_MAX constants.
  - Unit-select enum SEC/MIN/HR.
- Sub-module btn_edge (clk, clear_n, btn, rise): one instance each for mode_btn and inc_btn.
- Scan pointer and FSM stay in the top module.

Test Plan:
- Reset: hold clear_n=0 for 2 cycles with buttons high -> every output 0, mode=00. Buttons stay high after release -> no action until a fresh rising edge.
- RUN scan: bench counters hold sec=12, min=34, hr=5 -> enables rotate sec,min,hr each cycle. Within 3 cycles disp_sec=12, disp_min=34, disp_hr=5. count_en mirrors tick_1hz.
- Hour edit wrap: hr=22, mode press, two inc presses -> edit_val goes 22->23->0. Next mode press gives hr_load=1 with load_data=0 for one cycle, then min_en high for one cycle.
- Full cycle: edit minutes 59 +1 -> 0, seconds 30 +2 -> 32 -> min_load with 0, then sec_load with 32, then mode=00. tick_1hz pulses during edit give count_en=0 throughout.
- Simultaneous edges: in EDIT_MIN with edit_val=10, mode and inc rise on the same cycle -> min_load with data 10, state FETCH_SEC.
- Reset mid-edit: clear_n=0 during EDIT_SEC -> no sec_load pulse ever, state RUN, edit_val=0.

Source files
------------

// File: rtl/time_ctrl_pkg.sv
// Shared types and constants for the clock time-set controller.
//   state_t : controller FSM states (RUN plus a FETCH/EDIT pair per unit)
//   unit_t  : counter unit selected by the RUN-mode readback scan
//   MODE_*  : 2-bit codes presented on the mode output
package time_ctrl_pkg;

  localparam int W_DEF      = 6;
  localparam int HR_MAX_DEF = 23;
  localparam int MS_MAX_DEF = 59;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_FETCH_HR  = 3'd1,
    ST_EDIT_HR   = 3'd2,
    ST_FETCH_MIN = 3'd3,
    ST_EDIT_MIN  = 3'd4,
    ST_FETCH_SEC = 3'd5,
    ST_EDIT_SEC  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    UNIT_SEC = 2'd0,
    UNIT_MIN = 2'd1,
    UNIT_HR  = 2'd2
  } unit_t;

  localparam logic [1:0] MODE_RUN = 2'b00;
  localparam logic [1:0] MODE_HR  = 2'b01;
  localparam logic [1:0] MODE_MIN = 2'b10;
  localparam logic [1:0] MODE_SEC = 2'b11;

  // Readback scan order: SEC -> MIN -> HR -> SEC.
  function automatic unit_t next_unit(input unit_t u);
    unit_t n;
    case (u)
      UNIT_SEC: n = UNIT_MIN;
      UNIT_MIN: n = UNIT_HR;
      default:  n = UNIT_SEC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level.
//   clk     : system clock
//   clear_n : synchronous active-low reset
//   btn     : debounced button level
//   rise    : high for the single cycle in which a fresh press is seen
// A button held through reset must first be seen released before a press
// counts; r_armed provides that, so reset never manufactures a press.
module btn_edge (
  input  logic clk,
  input  logic clear_n,
  input  logic btn,
  output logic rise
);

  logic r_prev;
  logic r_armed;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev <= btn;
      if (!btn) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign rise = btn & ~r_prev & r_armed;

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/edit controller for the hour, minute and second counter units.
// Owns the shared readback bus enables. In RUN it forwards the 1 Hz tick
// and round-robin scans the counters into display registers; in SET it
// fetches one unit, edits it with the increment button and loads it back.
//   clk, clear_n               : clock, synchronous active-low reset
//   mode_btn, inc_btn          : debounced button levels (rising edge acts)
//   tick_1hz                   : one-cycle seconds pulse
//   databus                    : shared readback bus from the counters
//   count_en                   : gated tick to the seconds chain
//   sec_en, min_en, hr_en      : bus enables (one-hot or zero)
//   sec_load, min_load, hr_load: registered one-cycle load strobes
//   load_data                  : value accompanying a load strobe
//   disp_sec, disp_min, disp_hr: scanned display values
//   edit_val                   : value being edited
//   mode                       : 00 RUN, 01 HR, 10 MIN, 11 SEC
//   dbg_state                  : raw FSM state for observation
//
// Handshake: there is no back-pressure. A bus enable asserted in a cycle
// means databus carries that unit's value in the same cycle and is
// captured at the closing edge; a load strobe is a fire-and-forget
// one-cycle command that the addressed counter must accept.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int HR_MAX = HR_MAX_DEF,
  parameter int MS_MAX = MS_MAX_DEF
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         mode_btn,
  input  logic         inc_btn,
  input  logic         tick_1hz,
  input  logic [W-1:0] databus,
  output logic         count_en,
  output logic         sec_en,
  output logic         min_en,
  output logic         hr_en,
  output logic         sec_load,
  output logic         min_load,
  output logic         hr_load,
  output logic [W-1:0] load_data,
  output logic [W-1:0] disp_sec,
  output logic [W-1:0] disp_min,
  output logic [W-1:0] disp_hr,
  output logic [W-1:0] edit_val,
  output logic [1:0]   mode,
  output logic [2:0]   dbg_state
);

  localparam logic [W-1:0] HR_MAX_W = W'(HR_MAX);
  localparam logic [W-1:0] MS_MAX_W = W'(MS_MAX);

  logic w_mode_rise;
  logic w_inc_rise;

  btn_edge u_mode_edge (
    .clk     (clk),
    .clear_n (clear_n),
    .btn     (mode_btn),
    .rise    (w_mode_rise)
  );

  btn_edge u_inc_edge (
    .clk     (clk),
    .clear_n (clear_n),
    .btn     (inc_btn),
    .rise    (w_inc_rise)
  );

  state_t       r_state;
  state_t       w_state_nxt;
  unit_t        r_scan;
  // Low only in the reset cycle(s); keeps the bus enables quiet in reset
  // even though the scan pointer already rests at SEC.
  logic         r_live;
  logic [W-1:0] r_edit;
  logic [W-1:0] r_disp_sec;
  logic [W-1:0] r_disp_min;
  logic [W-1:0] r_disp_hr;
  logic [W-1:0] r_load_data;
  logic         r_sec_load;
  logic         r_min_load;
  logic         r_hr_load;

  logic         w_sec_en;
  logic         w_min_en;
  logic         w_hr_en;
  logic         w_count_en;
  logic [1:0]   w_mode;
  logic         w_any_load;
  logic         w_editing;
  logic [W-1:0] w_edit_max;
  logic [W-1:0] w_edit_inc;

  assign w_any_load = r_sec_load | r_min_load | r_hr_load;

  always_comb begin
    w_state_nxt = r_state;
    w_sec_en    = 1'b0;
    w_min_en    = 1'b0;
    w_hr_en     = 1'b0;
    w_count_en  = 1'b0;
    w_mode      = MODE_RUN;
    w_editing   = 1'b0;
    case (r_state)
      ST_RUN: begin
        // The seconds load from EDIT_SEC lands in the first RUN cycle; a
        // tick in that cycle is dropped so load and count never collide.
        w_count_en = r_live & tick_1hz & ~w_any_load;
        if (r_live) begin
          case (r_scan)
            UNIT_SEC: w_sec_en = 1'b1;
            UNIT_MIN: w_min_en = 1'b1;
            default:  w_hr_en  = 1'b1;
          endcase
        end
        if (w_mode_rise) begin
          w_state_nxt = ST_FETCH_HR;
        end
      end
      ST_FETCH_HR: begin
        w_mode      = MODE_HR;
        w_hr_en     = 1'b1;
        w_state_nxt = ST_EDIT_HR;
      end
      ST_EDIT_HR: begin
        w_mode    = MODE_HR;
        w_editing = 1'b1;
        if (w_mode_rise) begin
          w_state_nxt = ST_FETCH_MIN;
        end
      end
      ST_FETCH_MIN: begin
        w_mode      = MODE_MIN;
        w_min_en    = 1'b1;
        w_state_nxt = ST_EDIT_MIN;
      end
      ST_EDIT_MIN: begin
        w_mode    = MODE_MIN;
        w_editing = 1'b1;
        if (w_mode_rise) begin
          w_state_nxt = ST_FETCH_SEC;
        end
      end
      ST_FETCH_SEC: begin
        w_mode      = MODE_SEC;
        w_sec_en    = 1'b1;
        w_state_nxt = ST_EDIT_SEC;
      end
      ST_EDIT_SEC: begin
        w_mode    = MODE_SEC;
        w_editing = 1'b1;
        if (w_mode_rise) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Values above the unit's maximum (e.g. garbage fetched from a counter)
  // also wrap to zero on the first increment.
  assign w_edit_max = (r_state == ST_EDIT_HR) ? HR_MAX_W : MS_MAX_W;
  assign w_edit_inc = (r_edit >= w_edit_max) ? '0 : r_edit + 1'b1;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state     <= ST_RUN;
      r_scan      <= UNIT_SEC;
      r_live      <= 1'b0;
      r_edit      <= '0;
      r_disp_sec  <= '0;
      r_disp_min  <= '0;
      r_disp_hr   <= '0;
      r_load_data <= '0;
      r_sec_load  <= 1'b0;
      r_min_load  <= 1'b0;
      r_hr_load   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_live     <= 1'b1;
      r_sec_load <= 1'b0;
      r_min_load <= 1'b0;
      r_hr_load  <= 1'b0;

      // Scan only advances in RUN; parking it at SEC elsewhere makes the
      // return to RUN restart the rotation at SEC.
      if (r_state == ST_RUN && r_live) begin
        r_scan <= next_unit(r_scan);
      end else begin
        r_scan <= UNIT_SEC;
      end

      if (w_sec_en && r_state == ST_RUN) r_disp_sec <= databus;
      if (w_min_en && r_state == ST_RUN) r_disp_min <= databus;
      if (w_hr_en  && r_state == ST_RUN) r_disp_hr  <= databus;

      if (r_state == ST_FETCH_HR || r_state == ST_FETCH_MIN ||
          r_state == ST_FETCH_SEC) begin
        r_edit <= databus;
      end

      // Mode beats inc: a commit stores the pre-increment value.
      if (w_editing) begin
        if (w_mode_rise) begin
          r_load_data <= r_edit;
          r_hr_load   <= (r_state == ST_EDIT_HR);
          r_min_load  <= (r_state == ST_EDIT_MIN);
          r_sec_load  <= (r_state == ST_EDIT_SEC);
        end else if (w_inc_rise) begin
          r_edit <= w_edit_inc;
        end
      end
    end
  end

  assign count_en  = w_count_en;
  assign sec_en    = w_sec_en;
  assign min_en    = w_min_en;
  assign hr_en     = w_hr_en;
  assign sec_load  = r_sec_load;
  assign min_load  = r_min_load;
  assign hr_load   = r_hr_load;
  assign load_data = r_load_data;
  assign disp_sec  = r_disp_sec;
  assign disp_min  = r_disp_min;
  assign disp_hr   = r_disp_hr;
  assign edit_val  = r_edit;
  assign mode      = w_mode;
  assign dbg_state = r_state;

endmodule
